lcd_layer_arbiter: RTL and testbench
====================================

LCD_LAYER_ARBITER -- requirements
Module: lcd_layer_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 480, active pixels per line.
- V_ACTIVE, 272, active lines per frame.
- BALL_SIZE, 8, ball width and height in pixels.
- PAD_W, 8, paddle width.
- PAD_H, 48, paddle height.
- C_BG, 24'h000000, background color.
- C_BALL, 24'hFFFFFF, ball color.
- C_PAD, 24'h00FF00, paddle color.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_clk, in, 1, pixel clock (same clock as the timing generator).
- i_rst, in, 1, asynchronous active-high reset.
- i_x, in, 9, current column from the timing generator.
- i_y, in, 9, current row from the timing generator.
- i_data_enable, in, 1, active-video flag.
- i_upd_valid, in, 1, position update request.
- i_upd_id, in, 2, update target: 0 = ball, 1 = left paddle, 2 = right paddle, 3 = reserved.
- i_upd_x, in, 9, new top-left x.
- i_upd_y, in, 9, new top-left y.
- o_upd_ready, out, 1, update accepted when high with i_upd_valid.
- o_color, out, 24, pixel color {R,G,B}.
- o_data_enable, out, 1, i_data_enable delayed to align with o_color.
- o_frame, out, 8, committed-frame counter.
- o_frame_tick, out, 1, one-cycle pulse on commit.
- o_collision, out, 1, ball/paddle overlap seen in the last frame.

Function
REQ-003 Latency SHALL be exactly 1 cycle: o_color and o_data_enable are registered from i_x, i_y and i_data_enable of the previous cycle.
REQ-004 o_color SHALL be 24'h0 whenever the registered data-enable is 0.
REQ-005 A layer SHALL be hit when pos_x <= x < pos_x + width and pos_y <= y < pos_y + height; sums SHALL be computed at 10 bits, with no wrap.
REQ-006 Priority SHALL be ball > left paddle > right paddle > C_BG.
REQ-007 An update SHALL transfer on a cycle with i_upd_valid & o_upd_ready; it writes the shadow register of i_upd_id only and never the active register.
REQ-008 The update handshake SHALL obey these rules.
- id 3 is accepted and discarded.
- A later update to the same id in the same frame overwrites the earlier one.
- An update with x > H_ACTIVE - width SHALL be clamped to H_ACTIVE - width; y is likewise clamped against V_ACTIVE - height.
REQ-009 The state machine SHALL have three states: WAIT_FRAME, RUN and COMMIT.
- WAIT_FRAME: render C_BG only; on frame end go to COMMIT.
- RUN: render layers; on frame end go to COMMIT.
- COMMIT: exactly 1 cycle, then RUN.
REQ-010 Frame end SHALL be the cycle with i_data_enable = 1, i_x = H_ACTIVE-1 and i_y = V_ACTIVE-1.
REQ-011 In COMMIT the block SHALL do all of the following.
- Copy all shadow registers to the active registers.
- Pulse o_frame_tick.
- Increment o_frame (255 wraps to 0).
- Hold o_upd_ready at 0.
REQ-012 o_upd_ready SHALL be 1 in WAIT_FRAME and RUN and 0 in COMMIT; an update presented during COMMIT SHALL stay pending and be accepted on the next cycle.
REQ-013 Active positions SHALL NOT change during active video; a mid-frame update SHALL affect rendering only from the next frame.

Reset
REQ-014 Reset SHALL drive the following values.
- o_color = 0, o_data_enable = 0, o_frame = 0, o_frame_tick = 0, o_collision = 0, o_upd_ready = 0.
- State = WAIT_FRAME.
- Ball active/shadow = ((H_ACTIVE-BALL_SIZE)/2, (V_ACTIVE-BALL_SIZE)/2).
- Left paddle = (8, (V_ACTIVE-PAD_H)/2).
- Right paddle = (H_ACTIVE-8-PAD_W, (V_ACTIVE-PAD_H)/2).
REQ-015 o_upd_ready SHALL go to 1 on the first clock edge after i_rst deasserts.
REQ-016 Reset asserted mid-frame or mid-transfer SHALL discard every shadow write not yet committed.

Configuration
REQ-017 Macro LCD_COLLISION_DETECT_EN SHALL control collision detection.
- Defined: an internal sticky flag sets on any active pixel where the ball and either paddle both hit. At COMMIT the flag is copied to o_collision and cleared; a hit on the frame-end pixel itself SHALL be included in the copy.
- Undefined: o_collision is tied to 0 and no flag logic is synthesized.

Verification
REQ-018 Reset release, first full frame: o_color = C_BG for all active pixels; o_frame_tick pulses once; o_frame = 1; the second frame shows sprites at the reset positions.
REQ-019 In RUN, ball update (100,50) at row 10: the current frame is unchanged; the next frame shows C_BALL at x 100..107, y 50..57, and a 1-cycle delayed o_color matches.
REQ-020 i_upd_valid held high across COMMIT: o_upd_ready = 0 for exactly that cycle; the transfer completes on the following cycle; the data is not lost.
REQ-021 Right paddle update (479,300): clamped to (472,224); pixel (479,271) = C_PAD in the next frame.
REQ-022 With LCD_COLLISION_DETECT_EN, ball placed overlapping the left paddle: o_collision = 1 after the next commit and 0 one frame after the overlap is removed; o_frame wraps 255 to 0 across frames.

Source files
------------

// File: rtl/lcd_layer_arbiter.sv
`timescale 1ns/1ps
// Layer compositor for a ball and two paddles over a background, one-cycle registered output.
// Optional feature macro: LCD_COLLISION_DETECT_EN (ball/paddle overlap flag on o_collision).
module lcd_layer_arbiter #(
    parameter int unsigned H_ACTIVE  = 480,
    parameter int unsigned V_ACTIVE  = 272,
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned PAD_W     = 8,
    parameter int unsigned PAD_H     = 48,
    parameter logic [23:0] C_BG      = 24'h000000,
    parameter logic [23:0] C_BALL    = 24'hFFFFFF,
    parameter logic [23:0] C_PAD     = 24'h00FF00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [8:0]  i_x,
    input  logic [8:0]  i_y,
    input  logic        i_data_enable,
    input  logic        i_upd_valid,
    input  logic [1:0]  i_upd_id,
    input  logic [8:0]  i_upd_x,
    input  logic [8:0]  i_upd_y,
    output logic        o_upd_ready,
    output logic [23:0] o_color,
    output logic        o_data_enable,
    output logic [7:0]  o_frame,
    output logic        o_frame_tick,
    output logic        o_collision
);
    typedef logic [8:0] coord_t;
    typedef struct packed {
        coord_t x;
        coord_t y;
    } pos_t;
    typedef enum logic [1:0] {WAIT_FRAME, RUN, COMMIT} state_t;

    localparam int unsigned L_BALL  = 0;
    localparam int unsigned L_LEFT  = 1;
    localparam int unsigned L_RIGHT = 2;

    localparam logic [9:0] BALL_W10  = 10'(BALL_SIZE);
    localparam logic [9:0] PAD_W10   = 10'(PAD_W);
    localparam logic [9:0] PAD_H10   = 10'(PAD_H);
    localparam logic [9:0] BALL_XMAX = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0] BALL_YMAX = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] PAD_XMAX  = 10'(H_ACTIVE - PAD_W);
    localparam logic [9:0] PAD_YMAX  = 10'(V_ACTIVE - PAD_H);
    localparam coord_t     PAD_Y0    = 9'((V_ACTIVE - PAD_H) / 2);

    localparam pos_t [2:0] RESET_POS = {
        pos_t'{x: 9'(H_ACTIVE - 8 - PAD_W), y: PAD_Y0},
        pos_t'{x: 9'd8, y: PAD_Y0},
        pos_t'{x: 9'((H_ACTIVE - BALL_SIZE) / 2), y: 9'((V_ACTIVE - BALL_SIZE) / 2)}
    };

    // Comparisons run at 10 bits so pos + size never wraps past the 9-bit coordinate range.
    function automatic logic hit(coord_t px, coord_t py, pos_t p, logic [9:0] w, logic [9:0] h);
        logic [9:0] x10, y10, ox, oy;
        x10 = {1'b0, px};
        y10 = {1'b0, py};
        ox  = {1'b0, p.x};
        oy  = {1'b0, p.y};
        return (x10 >= ox) && (x10 < ox + w) && (y10 >= oy) && (y10 < oy + h);
    endfunction

    function automatic coord_t clamp(coord_t v, logic [9:0] lim);
        return ({1'b0, v} > lim) ? lim[8:0] : v;
    endfunction

    state_t      state_q, state_d;
    pos_t [2:0]  shadow_q, shadow_d;
    pos_t [2:0]  active_q, active_d;
    logic [23:0] color_q, color_d;
    logic        de_q;
    logic [7:0]  frame_q, frame_d;
    logic        tick_q, tick_d;
    logic        upd_ready_q, upd_ready_d;

    logic frame_end, hit_ball, hit_left, hit_right;

    assign frame_end = i_data_enable && (i_x == 9'(H_ACTIVE - 1)) && (i_y == 9'(V_ACTIVE - 1));
    assign hit_ball  = hit(i_x, i_y, active_q[L_BALL],  BALL_W10, BALL_W10);
    assign hit_left  = hit(i_x, i_y, active_q[L_LEFT],  PAD_W10,  PAD_H10);
    assign hit_right = hit(i_x, i_y, active_q[L_RIGHT], PAD_W10,  PAD_H10);

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_FRAME: if (frame_end) state_d = COMMIT;
            RUN:        if (frame_end) state_d = COMMIT;
            COMMIT:     state_d = RUN;
            default:    state_d = WAIT_FRAME;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        if (i_upd_valid && upd_ready_q) begin
            case (i_upd_id)
                2'd0: shadow_d[L_BALL]  = '{x: clamp(i_upd_x, BALL_XMAX), y: clamp(i_upd_y, BALL_YMAX)};
                2'd1: shadow_d[L_LEFT]  = '{x: clamp(i_upd_x, PAD_XMAX),  y: clamp(i_upd_y, PAD_YMAX)};
                2'd2: shadow_d[L_RIGHT] = '{x: clamp(i_upd_x, PAD_XMAX),  y: clamp(i_upd_y, PAD_YMAX)};
                default: ;
            endcase
        end
        active_d    = (state_q == COMMIT) ? shadow_q : active_q;
        frame_d     = (state_q == COMMIT) ? frame_q + 8'd1 : frame_q;
        tick_d      = (state_d == COMMIT);
        upd_ready_d = (state_d != COMMIT);
    end

    always_comb begin
        color_d = 24'h0;
        if (i_data_enable) begin
            if (state_q == WAIT_FRAME) color_d = C_BG;
            else if (hit_ball)         color_d = C_BALL;
            else if (hit_left)         color_d = C_PAD;
            else if (hit_right)        color_d = C_PAD;
            else                       color_d = C_BG;
        end
    end

    // NOTE: shadow and active position registers are reset too, so a reset discards pending writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= WAIT_FRAME;
            shadow_q    <= RESET_POS;
            active_q    <= RESET_POS;
            color_q     <= 24'h0;
            de_q        <= 1'b0;
            frame_q     <= 8'd0;
            tick_q      <= 1'b0;
            upd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            color_q     <= color_d;
            de_q        <= i_data_enable;
            frame_q     <= frame_d;
            tick_q      <= tick_d;
            upd_ready_q <= upd_ready_d;
        end
    end

`ifdef LCD_COLLISION_DETECT_EN
    logic coll_flag_q, coll_flag_d;
    logic collision_q, collision_d;

    // The frame-end pixel is registered into the flag before COMMIT samples it.
    always_comb begin
        coll_flag_d = coll_flag_q;
        collision_d = collision_q;
        if (state_q == COMMIT) begin
            collision_d = coll_flag_q;
            coll_flag_d = 1'b0;
        end
        if (i_data_enable && (state_q != WAIT_FRAME) && hit_ball && (hit_left || hit_right))
            coll_flag_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            coll_flag_q <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            coll_flag_q <= coll_flag_d;
            collision_q <= collision_d;
        end
    end

    assign o_collision = collision_q;
`else
    assign o_collision = 1'b0;
`endif

    assign o_upd_ready   = upd_ready_q;
    assign o_color       = color_q;
    assign o_data_enable = de_q;
    assign o_frame       = frame_q;
    assign o_frame_tick  = tick_q;
endmodule

// File: tb/tb_lcd_layer_arbiter.sv
`timescale 1ns/1ps
// Directed, table-driven bench for lcd_layer_arbiter using the default 480x272 geometry.
module tb_lcd_layer_arbiter;
    localparam logic [23:0] BG   = 24'h123456;
    localparam logic [23:0] BALL = 24'hFFFFFF;
    localparam logic [23:0] PAD  = 24'h00FF00;
`ifdef LCD_COLLISION_DETECT_EN
    localparam logic COLL = 1'b1;
`else
    localparam logic COLL = 1'b0;
`endif

    logic        i_clk, i_rst;
    logic [8:0]  i_x, i_y;
    logic        i_data_enable;
    logic        i_upd_valid;
    logic [1:0]  i_upd_id;
    logic [8:0]  i_upd_x, i_upd_y;
    logic        o_upd_ready;
    logic [23:0] o_color;
    logic        o_data_enable;
    logic [7:0]  o_frame;
    logic        o_frame_tick;
    logic        o_collision;

    lcd_layer_arbiter #(.C_BG(BG)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y), .i_data_enable(i_data_enable),
        .i_upd_valid(i_upd_valid), .i_upd_id(i_upd_id), .i_upd_x(i_upd_x), .i_upd_y(i_upd_y),
        .o_upd_ready(o_upd_ready), .o_color(o_color), .o_data_enable(o_data_enable),
        .o_frame(o_frame), .o_frame_tick(o_frame_tick), .o_collision(o_collision)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        int          tag;
        int          x;
        int          y;
        bit          de;
        logic [23:0] color;
    } vec_t;
    vec_t vecs[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(int tag, int x, int y, bit de, logic [23:0] c);
        vec_t v;
        v.tag = tag; v.x = x; v.y = y; v.de = de; v.color = c;
        vecs.push_back(v);
    endfunction

    task automatic pix(int x, int y, bit de);
        i_x = 9'(x);
        i_y = 9'(y);
        i_data_enable = de;
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_tag(int tag);
        foreach (vecs[i]) begin
            if (vecs[i].tag == tag) begin
                pix(vecs[i].x, vecs[i].y, vecs[i].de);
                check($sformatf("t%0d color(%0d,%0d)", tag, vecs[i].x, vecs[i].y), 32'(o_color), 32'(vecs[i].color));
                check($sformatf("t%0d de(%0d,%0d)", tag, vecs[i].x, vecs[i].y), 32'(o_data_enable), 32'(vecs[i].de));
            end
        end
    endtask

    task automatic upd(int id, int x, int y);
        i_upd_valid = 1'b1;
        i_upd_id = 2'(id);
        i_upd_x = 9'(x);
        i_upd_y = 9'(y);
        check("upd_ready before transfer", 32'(o_upd_ready), 32'd1);
        pix(0, 10, 1'b1);
        i_upd_valid = 1'b0;
    endtask

    task automatic end_frame(logic [23:0] end_color, int exp_frame);
        pix(479, 271, 1'b1);
        check("frame-end pixel color", 32'(o_color), 32'(end_color));
        check("tick in commit", 32'(o_frame_tick), 32'd1);
        check("ready in commit", 32'(o_upd_ready), 32'd0);
        check("frame before commit", 32'(o_frame), 32'((exp_frame + 255) % 256));
        pix(0, 0, 1'b0);
        check("tick after commit", 32'(o_frame_tick), 32'd0);
        check("ready after commit", 32'(o_upd_ready), 32'd1);
        check("frame after commit", 32'(o_frame), 32'(exp_frame % 256));
    endtask

    task automatic check_reset_outputs();
        check("rst color", 32'(o_color), 32'd0);
        check("rst de", 32'(o_data_enable), 32'd0);
        check("rst frame", 32'(o_frame), 32'd0);
        check("rst tick", 32'(o_frame_tick), 32'd0);
        check("rst collision", 32'(o_collision), 32'd0);
        check("rst ready", 32'(o_upd_ready), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Waiting frame: background only, even where sprites sit.
        add(0, 236, 132, 1, BG);  add(0, 8, 112, 1, BG);   add(0, 464, 112, 1, BG);
        add(0, 100, 100, 0, 24'h0);
        // First rendered frame at reset positions.
        add(1, 236, 132, 1, BALL); add(1, 243, 139, 1, BALL); add(1, 244, 139, 1, BG);
        add(1, 235, 132, 1, BG);   add(1, 236, 140, 1, BG);
        add(1, 8, 112, 1, PAD);    add(1, 15, 159, 1, PAD);   add(1, 16, 112, 1, BG);
        add(1, 8, 160, 1, BG);     add(1, 464, 112, 1, PAD);  add(1, 471, 159, 1, PAD);
        add(1, 472, 112, 1, BG);   add(1, 236, 132, 0, 24'h0);
        // Same frame after updates: nothing moves yet.
        add(11, 100, 50, 1, BG);   add(11, 236, 132, 1, BALL); add(11, 200, 100, 1, BG);
        add(11, 8, 112, 1, PAD);   add(11, 472, 224, 1, BG);   add(11, 50, 50, 1, BG);
        // Frame with committed updates.
        add(2, 100, 50, 1, BALL);  add(2, 107, 57, 1, BALL);  add(2, 108, 57, 1, BG);
        add(2, 100, 58, 1, BG);    add(2, 99, 50, 1, BG);     add(2, 236, 132, 1, BG);
        add(2, 200, 100, 1, PAD);  add(2, 207, 147, 1, PAD);  add(2, 300, 0, 1, BG);
        add(2, 8, 112, 1, BG);     add(2, 472, 224, 1, PAD);  add(2, 471, 224, 1, BG);
        add(2, 472, 223, 1, BG);   add(2, 50, 50, 1, BG);
        // Ball overlapping the right paddle: ball wins.
        add(3, 470, 230, 1, BALL); add(3, 472, 230, 1, BALL); add(3, 477, 237, 1, BALL);
        add(3, 478, 230, 1, PAD);  add(3, 469, 230, 1, BG);   add(3, 470, 229, 1, BG);
        // Ball in the top-left corner.
        add(4, 0, 0, 1, BALL);     add(4, 7, 7, 1, BALL);     add(4, 8, 8, 1, BG);
        // After a mid-frame reset: reset positions again.
        add(20, 236, 132, 1, BALL); add(20, 10, 10, 1, BG);   add(20, 8, 112, 1, PAD);
        add(20, 464, 112, 1, PAD);  add(20, 200, 100, 1, BG); add(20, 472, 224, 1, BG);

        i_rst = 1'b0; i_x = '0; i_y = '0; i_data_enable = 1'b0;
        i_upd_valid = 1'b0; i_upd_id = '0; i_upd_x = '0; i_upd_y = '0;
        #2 i_rst = 1'b1;
        @(posedge i_clk); @(posedge i_clk); #1;
        check_reset_outputs();
        i_rst = 1'b0;
        #1 check("ready before first edge", 32'(o_upd_ready), 32'd0);
        pix(0, 0, 1'b0);
        check("ready after first edge", 32'(o_upd_ready), 32'd1);

        run_tag(0);
        end_frame(BG, 1);

        run_tag(1);
        upd(0, 100, 50);
        upd(1, 300, 0);
        upd(1, 200, 100);
        upd(3, 50, 50);
        upd(2, 479, 300);
        run_tag(11);

        // Update presented during COMMIT must wait one cycle and survive.
        pix(479, 271, 1'b1);
        check("f1 end color", 32'(o_color), 32'(BG));
        check("f1 commit tick", 32'(o_frame_tick), 32'd1);
        check("f1 commit ready", 32'(o_upd_ready), 32'd0);
        i_upd_valid = 1'b1; i_upd_id = 2'd0; i_upd_x = 9'd470; i_upd_y = 9'd230;
        pix(0, 0, 1'b0);
        check("ready after commit (held)", 32'(o_upd_ready), 32'd1);
        check("frame after f1", 32'(o_frame), 32'd2);
        pix(0, 0, 1'b0);
        i_upd_valid = 1'b0;
        check("ready during held transfer", 32'(o_upd_ready), 32'd1);

        run_tag(2);
        end_frame(PAD, 3);
        check("collision after f2", 32'(o_collision), 32'd0);

        run_tag(3);
        upd(0, 0, 0);
        end_frame(PAD, 4);
        check("collision after f3", 32'(o_collision), 32'(COLL));

        run_tag(4);
        upd(0, 472, 264);
        end_frame(PAD, 5);
        check("collision after f4", 32'(o_collision), 32'd0);

        // Only the frame-end pixel overlaps in this frame.
        end_frame(BALL, 6);
        check("collision from end pixel", 32'(o_collision), 32'(COLL));

        for (int f = 7; f <= 256; f++) end_frame(BALL, f);
        check("frame wrapped", 32'(o_frame), 32'd0);

        upd(0, 10, 10);
        pix(5, 5, 1'b1);
        i_rst = 1'b1;
        #1 check_reset_outputs();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        pix(0, 0, 1'b0);
        check("ready after second reset", 32'(o_upd_ready), 32'd1);
        run_tag(0);
        end_frame(BG, 1);
        run_tag(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
